seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed driver for N common-anode seven-segment digits, generalising the dual-digit display.
//  Snapshots N hex inputs once per scan frame to prevent tearing.
//  Scans the digits with programmable drive and dead-time (anti-ghost) slots.
//  Supports per-digit blanking and leading-zero suppression, and outputs the registered sum of all digits for the LEDs.
// PARAMETERS
//  N_DIGITS   2    number of digits, >=1
//  DRIVE_CYC  50000  clk cycles per digit drive slot, >=1
//  GAP_CYC    0    clk cycles of dead time after each drive slot (all anodes off), >=0
//  SUM_W      derived localparam = 4 + $clog2(N_DIGITS) (5 when N_DIGITS=2)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           asynchronous, active-low reset
//  digits      in   4*N_DIGITS  hex values; digits[4i+3:4i] = digit i, shown on anode[i]
//  blank_mask  in   N_DIGITS    1 = force digit i dark
//  lzb_en      in   1           1 = suppress leading zeros
//  seg         out  7           segments {g,f,e,d,c,b,a}, active-low
//  anode       out  N_DIGITS    digit enables, active-low, at most one low
//  sum         out  SUM_W       unsigned sum of the snapshot digits
//  frame_start out  1           one-clk pulse in the LOAD cycle
// BEHAVIOUR
//  Reset value of every output while reset=0: seg=7'b1111111, anode=all 1, sum=0, frame_start=0.
//    Reset also clears idx, the slot counter and the snapshot registers. Reset is async and may
//    assert mid-slot; outputs go to reset values immediately.
//  FSM states: LOAD, DRIVE, GAP. The first rising edge after reset release enters LOAD.
//  LOAD (exactly 1 clk):
//    - capture digits, blank_mask and lzb_en into snapshot registers
//    - frame_start=1, anodes all high, seg blank
//    - next state DRIVE with idx=0
//  DRIVE (DRIVE_CYC clks):
//    - anode[idx]=0, seg = decode(snapshot digit idx)
//    - if the digit is blanked: anode[idx]=1, seg blank; slot timing is unchanged
//    - then GAP if GAP_CYC>0, else advance
//  GAP (GAP_CYC clks): anodes all high, seg blank; then advance.
//  Advance: idx<N_DIGITS-1 -> idx+1, DRIVE. idx==N_DIGITS-1 -> LOAD (wrap).
//  Frame length = 1 + N_DIGITS*(DRIVE_CYC+GAP_CYC) clks, constant for all inputs.
//  Blanking rule: digit i is dark if snapshot blank_mask[i]=1, OR if lzb_en=1 and i>0 and
//    all snapshot digits j>=i are zero. Digit 0 is never blanked by lzb.
//  seg, anode and frame_start are registered outputs (glitch-free). Inputs affect the display
//    only at the next LOAD.
//  sum: zero-extended add of all snapshot digits, registered, valid from the first DRIVE cycle
//    after LOAD and held for the whole frame. Blanking does not affect sum. No overflow is
//    possible at SUM_W.
//  Decode: 0-F to standard hex glyphs, active-low
//    (0=1000000, 1=1111001, 2=0100100, E=0000110, F=0001110).
//  N_DIGITS=1: idx stays 0; the FSM still cycles LOAD/DRIVE/GAP.
// STRUCTURE
//  Package seg7_pkg:
//    - typedef enum logic [1:0] {LOAD, DRIVE, GAP} scan_state_t
//    - SEG_BLANK = 7'b1111111
//    - function hex_to_seg7(logic [3:0]) returning logic [6:0]
//  Sub-module seg7_decode: a combinational 4->7 wrapper around hex_to_seg7, instantiated once
//    on the muxed snapshot digit.
//  Top holds the FSM, slot counter ($clog2(max(DRIVE_CYC,GAP_CYC,2)) bits), idx counter,
//    snapshot registers, lzb logic and sum adder tree.
// TESTING (bench params: N_DIGITS=4, DRIVE_CYC=4, GAP_CYC=1; frame = 21 clks)
//  1. Hold reset=0 and toggle clk -> seg=1111111, anode=1111, sum=0.
//     Release -> frame_start high exactly 1 clk, then anode=1110 for 4 clks, then 1111 for 1 clk.
//  2. digits=16'h21FE, lzb_en=0, mask=0 -> slots show E(0000110), F(0001110), 1(1111001),
//     2(0100100) on anode[0..3]; sum=32; frame_start period 21 clks.
//  3. digits=16'h0005, lzb_en=1 -> digits 1-3 dark (anode stays 1111, seg blank in their
//     slots); digit 0 shows 5. digits=16'h0000, lzb_en=1 -> only digit 0 lit, showing 0.
//  4. Change digits mid-frame from 16'h1111 to 16'h2222 -> remainder of the frame still shows
//     1s and sum=4; the next frame shows 2s and sum=8.
//  5. Assert reset during the digit-2 DRIVE slot -> outputs at reset values within the same
//     time step with no clk edge needed; after release, the scan restarts at LOAD and digit 0.
//  6. Rerun with GAP_CYC=0 and mask=4'b0100 -> no all-off cycles between digits;
//     digit 2 is dark; frame = 17 clks.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed
// seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRIVE,
    GAP
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] hex_to_seg7(
    input logic [3:0] h
  );
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to active-low seven-segment
// decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg7(hex_i);

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit common-anode scan driver with frame
// snapshot, dead-time slots and leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter  int N_DIGITS  = 2,
  parameter  int DRIVE_CYC = 50000,
  parameter  int GAP_CYC   = 0,
  localparam int SUM_W     = 4 + $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lzb_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   anode,
  output logic [SUM_W-1:0]      sum,
  output logic                  frame_start
);

  localparam int IDX_W =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CMAX0 =
    (DRIVE_CYC > GAP_CYC) ? DRIVE_CYC : GAP_CYC;
  localparam int CMAX = (CMAX0 < 2) ? 2 : CMAX0;
  localparam int CNT_W = $clog2(CMAX);

  localparam logic [CNT_W-1:0] DRV_LAST =
    CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE = 1;

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  go_q;
  logic [4*N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0]   mask_q;
  logic                  lzb_q;
  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   anode_q;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  fs_q;

  logic                  adv;
  logic [N_DIGITS-1:0]   dark;
  logic                  zero_run;
  logic [3:0]            cur_dig;
  logic [6:0]            dec_seg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    if (!go_q) begin
      state_d = LOAD;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
        DRIVE: begin
          if (cnt_q == DRV_LAST) begin
            if (GAP_CYC > 0) begin
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) adv = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
        default: state_d = LOAD;
      endcase
    end
    if (adv) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        state_d = LOAD;
        idx_d   = '0;
      end else begin
        state_d = DRIVE;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  // Scan from the top digit down so zero_run means
  // "this digit and every higher one is zero".
  always_comb begin
    zero_run = 1'b1;
    dark     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (dig_q[4*i +: 4] == 4'd0);
      dark[i]  = mask_q[i]
               | (lzb_q && (i > 0) && zero_run);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      sum_d = sum_d + SUM_W'(dig_q[4*i +: 4]);
    end
  end

  assign cur_dig = dig_q[{idx_d, 2'b00} +: 4];

  seg7_decode u_dec (
    .hex_i (cur_dig),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_q    <= 1'b0;
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      mask_q  <= '0;
      lzb_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      anode_q <= '1;
      sum_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      go_q    <= 1'b1;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fs_q    <= (state_d == LOAD);
      if (state_d == LOAD) begin
        dig_q  <= digits;
        mask_q <= blank_mask;
        lzb_q  <= lzb_en;
      end
      if (state_q == LOAD) sum_q <= sum_d;
      if (state_d == DRIVE && !dark[idx_d]) begin
        anode_q <= ~(ONE << idx_d);
        seg_q   <= dec_seg;
      end else begin
        anode_q <= '1;
        seg_q   <= SEG_BLANK;
      end
    end
  end

  assign seg         = seg_q;
  assign anode       = anode_q;
  assign sum         = sum_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: 4 digits, drive 4,
// with a gap-1 instance and a gap-0 instance.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  blank_mask = '0;
  logic        lzb_en = 1'b0;
  logic        use_b = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic [5:0] sum_a, sum_b;
  logic       fs_a, fs_b;

  wire [6:0] seg_s = use_b ? seg_b : seg_a;
  wire [3:0] an_s  = use_b ? an_b  : an_a;
  wire [5:0] sum_s = use_b ? sum_b : sum_a;
  wire       fs_s  = use_b ? fs_b  : fs_a;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .N_DIGITS (4),
    .DRIVE_CYC(4),
    .GAP_CYC  (1)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .blank_mask (blank_mask),
    .lzb_en     (lzb_en),
    .seg        (seg_a),
    .anode      (an_a),
    .sum        (sum_a),
    .frame_start(fs_a)
  );

  seg7_scan_mux #(
    .N_DIGITS (4),
    .DRIVE_CYC(4),
    .GAP_CYC  (0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .blank_mask (blank_mask),
    .lzb_en     (lzb_en),
    .seg        (seg_b),
    .anode      (an_b),
    .sum        (sum_b),
    .frame_start(fs_b)
  );

  function automatic logic [6:0] glyph(
    input logic [3:0] h
  );
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fs_s && n < budget);
    chk("fs_wait", 32'(fs_s), 32'd1);
  endtask

  // Entered in a LOAD cycle; leaves in the next LOAD.
  task automatic check_frame(
    input string       tag,
    input logic [15:0] dg,
    input logic [3:0]  dk,
    input logic [5:0]  sm,
    input int          gap,
    input int          mid_slot,
    input logic [15:0] mid_dg
  );
    logic [3:0] ea;
    logic [6:0] es;
    chk({tag, "_load_an"}, 32'(an_s), 32'hF);
    chk({tag, "_load_seg"}, 32'(seg_s), 32'h7F);
    for (int i = 0; i < 4; i++) begin
      if (i == mid_slot) digits = mid_dg;
      ea = dk[i] ? 4'hF : ~(4'b0001 << i);
      es = dk[i] ? 7'h7F : glyph(dg[4*i +: 4]);
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("%s_an%0d", tag, i),
            32'(an_s), 32'(ea));
        chk($sformatf("%s_seg%0d", tag, i),
            32'(seg_s), 32'(es));
        if (c == 0) begin
          chk($sformatf("%s_sum%0d", tag, i),
              32'(sum_s), 32'(sm));
          chk($sformatf("%s_fs%0d", tag, i),
              32'(fs_s), 32'd0);
        end
      end
      for (int g = 0; g < gap; g++) begin
        step();
        chk($sformatf("%s_gapan%0d", tag, i),
            32'(an_s), 32'hF);
        chk($sformatf("%s_gapseg%0d", tag, i),
            32'(seg_s), 32'h7F);
      end
    end
    step();
    chk({tag, "_period"}, 32'(fs_s), 32'd1);
  endtask

  initial begin
    // 1: reset values, then first frame
    repeat (3) step();
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_an", 32'(an_a), 32'hF);
    chk("rst_sum", 32'(sum_a), 32'd0);
    chk("rst_fs", 32'(fs_a), 32'd0);
    reset = 1'b1;
    step();
    chk("t1_fs", 32'(fs_a), 32'd1);
    check_frame("t1", 16'h0000, 4'b0000, 6'd0,
                1, -1, 16'h0);

    // 2: plain hex glyphs
    digits = 16'h21FE;
    wait_fs(40);
    check_frame("t2", 16'h21FE, 4'b0000, 6'd32,
                1, -1, 16'h0);

    // 3: leading-zero suppression
    digits = 16'h0005;
    lzb_en = 1'b1;
    wait_fs(40);
    check_frame("t3a", 16'h0005, 4'b1110, 6'd5,
                1, -1, 16'h0);
    digits = 16'h0000;
    wait_fs(40);
    check_frame("t3b", 16'h0000, 4'b1110, 6'd0,
                1, -1, 16'h0);

    // 4: mid-frame input change is deferred
    lzb_en = 1'b0;
    digits = 16'h1111;
    wait_fs(40);
    check_frame("t4a", 16'h1111, 4'b0000, 6'd4,
                1, 2, 16'h2222);
    check_frame("t4b", 16'h2222, 4'b0000, 6'd8,
                1, -1, 16'h0);

    // 5: async reset inside the digit-2 slot
    repeat (12) step();
    chk("t5_pre_an", 32'(an_a), 32'b1011);
    reset = 1'b0;
    #1;
    chk("t5_seg", 32'(seg_a), 32'h7F);
    chk("t5_an", 32'(an_a), 32'hF);
    chk("t5_sum", 32'(sum_a), 32'd0);
    chk("t5_fs", 32'(fs_a), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("t5_fs_restart", 32'(fs_a), 32'd1);
    check_frame("t5", 16'h2222, 4'b0000, 6'd8,
                1, -1, 16'h0);

    // 6: zero gap, digit 2 masked
    use_b = 1'b1;
    blank_mask = 4'b0100;
    digits = 16'h4321;
    wait_fs(40);
    check_frame("t6", 16'h4321, 4'b0100, 6'd10,
                0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
